// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_rx_pkg: shared state encoding and line-level bit constants
package serial_frame_rx_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/serial_frame_rx_out_buf.sv
// rx_out_buf: one-entry valid/ready holding register; a load into a full, unaccepted buffer is dropped
module rx_out_buf #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         dout_ready,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    output logic         full_drop
);
    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d, drop_q, drop_d, free, take;
    always_comb begin
        free    = !valid_q || dout_ready;
        take    = load && free;
        valid_d = take || (valid_q && !dout_ready);
        data_d  = take ? load_data : data_q;
        drop_d  = load && !free;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end
    assign dout       = data_q;
    assign dout_valid = valid_q;
    assign full_drop  = drop_q;
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/parity/stop frame receiver assembling LSB-first N-bit words
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int N          = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sin,
    input  logic         sin_valid,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy
);
    localparam int CW = $clog2(N + 1);
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   sh_q, sh_d;
    logic           par_q, par_d, mis_q, mis_d;
    logic           perr_q, perr_d, ferr_q, ferr_d, busy_q, busy_d;
    logic           load;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        par_d   = par_q;
        mis_d   = mis_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        load    = 1'b0;
        if (sin_valid) begin
            case (state_q)
                ST_IDLE: if (sin == START_BIT) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                    sh_d    = '0;
                    par_d   = PARITY_ODD;
                    mis_d   = 1'b0;
                end
                ST_DATA: begin
                    sh_d    = {sin, sh_q[N-1:1]};
                    par_d   = par_q ^ sin;
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(N - 1)) ? (PARITY_EN ? ST_PARITY : ST_STOP) : ST_DATA;
                end
                ST_PARITY: begin
                    mis_d   = par_q ^ sin;
                    state_d = ST_STOP;
                end
                default: begin
                    ferr_d  = sin != STOP_BIT;
                    perr_d  = mis_q;
                    load    = (sin == STOP_BIT) && !mis_q;
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = state_d != ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            mis_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            mis_q   <= mis_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end
    rx_out_buf #(.N(N)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_data  (sh_q),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full_drop  (overrun)
    );
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: frame-level reference model driving directed and random frames
module tb_serial_frame_rx;
    localparam logic PODD = 1'b0;
    logic clk = 1'b0, reset, sin, sin_valid, dout_ready;
    logic [7:0] dout;
    logic dout_valid, parity_err, frame_err, overrun, busy;
    int errs = 0, checks = 0;
    logic mv, ep, ef, eo, gap_busy_ok;
    logic [7:0] md;

    serial_frame_rx #(.N(8), .PARITY_EN(1'b1), .PARITY_ODD(PODD)) dut (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic b, input logic v, input logic ld, input logic [7:0] w);
        sin = b;
        sin_valid = v;
        ep = 1'b0;
        ef = 1'b0;
        eo = ld && mv && !dout_ready;
        if (ld && (!mv || dout_ready)) begin
            mv = 1'b1;
            md = w;
        end else if (mv && dout_ready) mv = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic gap(input int pct);
        if ($urandom_range(99) < pct) begin
            tick(1'($urandom_range(1)), 1'b0, 1'b0, 8'h0);
            gap_busy_ok = gap_busy_ok && busy;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int pct);
        logic pm, fe;
        tick(1'b0, 1'b1, 1'b0, 8'h0);
        gap(pct);
        for (int i = 0; i < 8; i++) begin
            tick(d[i], 1'b1, 1'b0, 8'h0);
            gap(pct);
        end
        tick(pb, 1'b1, 1'b0, 8'h0);
        gap(pct);
        pm = ((^d) ^ pb) != PODD;
        fe = !sb;
        tick(sb, 1'b1, !pm && !fe, d);
        ep = pm;
        ef = fe;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mv = 1'b0; ep = 1'b0; ef = 1'b0; eo = 1'b0;
    endtask

    task automatic test_reset();
        sin = 1'b1; sin_valid = 1'b0; dout_ready = 1'b0;
        do_reset();
        checks++;
        if ({dout_valid, parity_err, frame_err, overrun, busy} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 00000", {dout_valid, parity_err, frame_err, overrun, busy});
        end
        checks++;
        if (dout !== 8'h00) begin errs++; $display("FAIL reset_dout: got %h want 00", dout); end
    endtask

    task automatic test_basic();
        dout_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        checks++;
        if ({dout_valid, parity_err, frame_err, overrun} !== 4'b1000 || dout !== 8'hA5) begin
            errs++;
            $display("FAIL basic_load: got v/pe/fe/ov=%b dout=%h want 1000 a5", {dout_valid, parity_err, frame_err, overrun}, dout);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h0);
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL basic_accept: got valid=%b busy=%b want 0 0", dout_valid, busy);
        end
    endtask

    task automatic test_parity();
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        checks++;
        if ({dout_valid, parity_err, frame_err, overrun, busy} !== 5'b01000) begin
            errs++;
            $display("FAIL parity_err: got v/pe/fe/ov/busy=%b want 01000", {dout_valid, parity_err, frame_err, overrun, busy});
        end
        tick(1'b1, 1'b1, 1'b0, 8'h0);
        checks++;
        if (parity_err !== 1'b0 || dout_valid !== 1'b0) begin
            errs++;
            $display("FAIL parity_pulse: got pe=%b valid=%b want 0 0", parity_err, dout_valid);
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        checks++;
        if ({dout_valid, parity_err, frame_err, overrun} !== 4'b0010) begin
            errs++;
            $display("FAIL frame_err: got v/pe/fe/ov=%b want 0010", {dout_valid, parity_err, frame_err, overrun});
        end
        send_frame(8'h81, 1'b0, 1'b1, 0);
        checks++;
        if ({dout_valid, frame_err} !== 2'b10 || dout !== 8'h81) begin
            errs++;
            $display("FAIL after_frame_err: got valid=%b fe=%b dout=%h want 1 0 81", dout_valid, frame_err, dout);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h0);
    endtask

    task automatic test_overrun();
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        send_frame(8'h22, 1'b0, 1'b1, 0);
        checks++;
        if ({dout_valid, overrun} !== 2'b11 || dout !== 8'h11) begin
            errs++;
            $display("FAIL overrun: got valid=%b ov=%b dout=%h want 1 1 11", dout_valid, overrun, dout);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h0);
        checks++;
        if ({dout_valid, overrun} !== 2'b10 || dout !== 8'h11) begin
            errs++;
            $display("FAIL overrun_hold: got valid=%b ov=%b dout=%h want 1 0 11", dout_valid, overrun, dout);
        end
        dout_ready = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 8'h0);
        checks++;
        if (dout_valid !== 1'b0) begin errs++; $display("FAIL overrun_drain: got valid=%b want 0", dout_valid); end
    endtask

    task automatic test_gaps();
        gap_busy_ok = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 100);
        checks++;
        if (gap_busy_ok !== 1'b1) begin errs++; $display("FAIL gap_busy: got %b want 1", gap_busy_ok); end
        checks++;
        if ({dout_valid, parity_err, frame_err, overrun} !== 4'b1000 || dout !== 8'h5A) begin
            errs++;
            $display("FAIL gaps: got v/pe/fe/ov=%b dout=%h want 1000 5a", {dout_valid, parity_err, frame_err, overrun}, dout);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        dout_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 0);
        d = 8'hC3;
        tick(1'b0, 1'b1, 1'b0, 8'h0);
        for (int i = 0; i < 4; i++) tick(d[i], 1'b1, 1'b0, 8'h0);
        sin = d[4];
        sin_valid = 1'b1;
        do_reset();
        checks++;
        if ({dout_valid, parity_err, frame_err, overrun, busy} !== 5'b0 || dout !== 8'h00) begin
            errs++;
            $display("FAIL reset_mid: got flags=%b dout=%h want 00000 00", {dout_valid, parity_err, frame_err, overrun, busy}, dout);
        end
        dout_ready = 1'b1;
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        checks++;
        if ({dout_valid, parity_err, frame_err, overrun} !== 4'b1000 || dout !== 8'hF0) begin
            errs++;
            $display("FAIL after_reset: got v/pe/fe/ov=%b dout=%h want 1000 f0", {dout_valid, parity_err, frame_err, overrun}, dout);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h0);
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            dout_ready = 1'($urandom_range(1));
            send_frame(d, (^d) ^ PODD ^ ($urandom_range(4) == 0), $urandom_range(5) != 0, 30);
            checks++;
            if ({dout_valid, parity_err, frame_err, overrun, busy} !== {mv, ep, ef, eo, 1'b0} || (mv && dout !== md)) begin
                errs++;
                $display("FAIL random_frame %0d: got v/pe/fe/ov/busy=%b dout=%h want %b %h", n,
                         {dout_valid, parity_err, frame_err, overrun, busy}, dout, {mv, ep, ef, eo, 1'b0}, md);
            end
            dout_ready = 1'($urandom_range(1));
            tick(1'b1, 1'($urandom_range(1)), 1'b0, 8'h0);
            checks++;
            if ({dout_valid, parity_err, frame_err, overrun} !== {mv, 3'b000} || (mv && dout !== md)) begin
                errs++;
                $display("FAIL random_idle %0d: got v/pe/fe/ov=%b dout=%h want %b %h", n,
                         {dout_valid, parity_err, frame_err, overrun}, dout, {mv, 3'b000}, md);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_gaps();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
